// File: rtl/register_file_8x32_pkg.sv
// Shared constants and types for the 8-entry register file and its write decoder.
package register_file_8x32_pkg;

  localparam int unsigned RF_DEPTH  = 8;
  localparam int unsigned RF_AW     = 3;
  localparam int unsigned RF_DATA_W = 32;
  localparam logic [RF_DATA_W-1:0] RF_RST_VAL = '0;

  typedef logic [RF_AW-1:0]    rf_addr_t;
  typedef logic [RF_DEPTH-1:0] rf_en_t;

endpackage

// File: rtl/register_file_8x32_3_to_8_decoder.sv
// 3-to-8 one-hot decoder producing per-register write enables.
module register_file_8x32_3_to_8_decoder
  import register_file_8x32_pkg::*;
(
  input  logic [RF_AW-1:0]    addr_i,
  output logic [RF_DEPTH-1:0] onehot_c_o
);

  // An unknown address matches no entry, so no enable is raised.
  always_comb begin
    onehot_c_o = '0;
    for (int unsigned i = 0; i < RF_DEPTH; i++) begin
      if (addr_i == RF_AW'(i)) onehot_c_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/register_file_8x32.sv
// 8-entry register file, one write port and two registered read ports with
// optional write-first bypass and optional hardwired-zero r0.
module register_file_8x32
  import register_file_8x32_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RF_AW-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RF_AW-1:0]  ra_addr,
  input  logic [RF_AW-1:0]  rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0]   rf_q [RF_DEPTH];
  logic [DATA_W-1:0]   rf_d [RF_DEPTH];
  logic [DATA_W-1:0]   ra_q, ra_d;
  logic [DATA_W-1:0]   rb_q, rb_d;
  logic [RF_DEPTH-1:0] dec_c;
  logic [RF_DEPTH-1:0] wr_en_c;

  register_file_8x32_3_to_8_decoder u_dec (
    .addr_i     (wr_addr),
    .onehot_c_o (dec_c)
  );

  always_comb begin
    wr_en_c = dec_c & {RF_DEPTH{we}};
    if (ZERO_R0) wr_en_c[0] = 1'b0;
  end

  always_comb begin
    for (int unsigned i = 0; i < RF_DEPTH; i++) begin
      rf_d[i] = rf_q[i];
      if (wr_en_c[i]) rf_d[i] = wr_data;
    end
  end

  // Read muxes see pre-edge contents; bypass forwards the in-flight write.
  always_comb begin
    ra_d = rf_q[ra_addr];
    rb_d = rf_q[rb_addr];
    if (BYPASS && we && (wr_addr == ra_addr)) ra_d = wr_data;
    if (BYPASS && we && (wr_addr == rb_addr)) rb_d = wr_data;
    if (ZERO_R0 && (ra_addr == '0)) ra_d = '0;
    if (ZERO_R0 && (rb_addr == '0)) rb_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= DATA_W'(RF_RST_VAL);
      end
      ra_q <= DATA_W'(RF_RST_VAL);
      rb_q <= DATA_W'(RF_RST_VAL);
    end else begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= rf_d[i];
      end
      ra_q <= ra_d;
      rb_q <= rb_d;
    end
  end

  assign ra_data = ra_q;
  assign rb_data = rb_q;

  a_wr_addr_known : assert property (@(posedge clk) disable iff (reset)
    we |-> !$isunknown(wr_addr))
    else $error("register_file_8x32: unknown wr_addr with we asserted");

endmodule

// File: tb/tb_register_file_8x32.sv
// Randomized and directed bench comparing three register-file configurations
// against an array-based reference model.
module tb_register_file_8x32;

  localparam int unsigned NCFG = 3;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  ra_addr;
  logic [2:0]  rb_addr;
  logic [31:0] ra_data [NCFG];
  logic [31:0] rb_data [NCFG];

  int n_tests;
  int n_fail;

  // Config 0: bypass, 1: read-first, 2: bypass + hardwired r0.
  bit    cfg_bp [NCFG] = '{1'b1, 1'b0, 1'b1};
  bit    cfg_zr [NCFG] = '{1'b0, 1'b0, 1'b1};
  string cfg_nm [NCFG] = '{"bp", "rf", "z0"};

  logic [31:0] mem   [NCFG][8];
  logic [31:0] exp_a [NCFG];
  logic [31:0] exp_b [NCFG];

  register_file_8x32 #(.DATA_W(32), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_dut_bp (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data[0]), .rb_data(rb_data[0]));

  register_file_8x32 #(.DATA_W(32), .BYPASS(1'b0), .ZERO_R0(1'b0)) u_dut_rf (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data[1]), .rb_data(rb_data[1]));

  register_file_8x32 #(.DATA_W(32), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_dut_z0 (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data[2]), .rb_data(rb_data[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int c, input logic [2:0] a);
    if (cfg_zr[c] && a == 3'd0) return 32'h0;
    if (cfg_bp[c] && we && wr_addr == a) return wr_data;
    return mem[c][a];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCFG; c++) begin
      for (int r = 0; r < 8; r++) mem[c][r] = 32'h0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("%s/%s/ra", tag, cfg_nm[c]), ra_data[c], exp_a[c]);
      check($sformatf("%s/%s/rb", tag, cfg_nm[c]), rb_data[c], exp_b[c]);
    end
  endtask

  // One clock: drive at negedge, evaluate model at posedge, compare 1 time unit later.
  task automatic step(input string tag, input logic w, input logic [2:0] wa,
                      input logic [31:0] wd, input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    we = w; wr_addr = wa; wr_data = wd; ra_addr = a; rb_addr = b;
    @(posedge clk);
    for (int c = 0; c < NCFG; c++) begin
      exp_a[c] = model_read(c, a);
      exp_b[c] = model_read(c, b);
    end
    for (int c = 0; c < NCFG; c++) begin
      if (w && !(cfg_zr[c] && wa == 3'd0)) mem[c][wa] = wd;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; ra_addr = '0; rb_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NCFG; c++) begin exp_a[c] = 32'h0; exp_b[c] = 32'h0; end
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) step("rd_zero", 1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i));

    step("wr5", 1'b1, 3'd5, 32'hDEADBEEF, 3'd0, 3'd0);
    step("rd5", 1'b0, 3'd0, 32'h0, 3'd5, 3'd4);

    step("byp3", 1'b1, 3'd3, 32'h0000_1234, 3'd3, 3'd3);
    step("rd3", 1'b0, 3'd0, 32'h0, 3'd3, 3'd3);

    for (int i = 0; i < 8; i++) step("fill", 1'b1, 3'(i), 32'(i) * 32'h1111_1111, 3'd7, 3'd6);
    for (int i = 0; i < 8; i++) step("sweep", 1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i));
    step("we0", 1'b0, 3'd2, 32'hFFFF_FFFF, 3'd2, 3'd2);
    step("r2keep", 1'b0, 3'd0, 32'h0, 3'd2, 3'd2);

    step("wr_r0", 1'b1, 3'd0, 32'h0000_FFFF, 3'd0, 3'd1);
    step("rd_r0", 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);

    for (int n = 0; n < 400; n++) begin
      step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 8; i++) step("refill", 1'b1, 3'(i), 32'(i) * 32'h1111_1111, 3'd6, 3'd7);
    step("pre_rst", 1'b0, 3'd0, 32'h0, 3'd6, 3'd7);

    // Asynchronous reset while the clock is low must clear outputs immediately.
    @(negedge clk);
    we = 1'b0; ra_addr = 3'd6; rb_addr = 3'd6;
    #1;
    reset = 1'b1;
    #1;
    model_clear();
    for (int c = 0; c < NCFG; c++) begin exp_a[c] = 32'h0; exp_b[c] = 32'h0; end
    check_all("async_rst");
    #1;
    reset = 1'b0;
    step("post_rst", 1'b0, 3'd0, 32'h0, 3'd6, 3'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
